// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS-subset CPU: sequences fetch/decode/execute/
// memory/writeback and drives every datapath select and write enable.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [2:0]       alu_ctl,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_I_EXEC   = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [CNT_W-1:0] RETIRE_ONE = 1;

  logic [3:0] next_state;

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_alu = ALU_ADD;
    endcase
  endfunction

  function automatic logic r_legal(input logic [5:0] fn);
    r_legal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
              (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (instr_done) retired <= retired + RETIRE_ONE;
    end
  end

  // Opcode/funct stay valid in the IR until the next FETCH, so later states re-decode them.
  always_comb begin
    next_state = S_FETCH;
    pc_we      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    alu_ctl    = 3'b000;
    pc_src     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        alu_src_b  = 2'd1;
        alu_ctl    = ALU_ADD;
        pc_we      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_ctl   = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:             next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           next_state = S_BRANCH;
          OP_J:                     next_state = S_JUMP;
          OP_JAL:                   next_state = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_I_EXEC;
          OP_RTYPE: begin
            if (r_legal(funct))     next_state = S_R_EXEC;
            else if (funct == FN_JR) next_state = S_JR;
            else                    illegal    = 1'b1;
          end
          default:                  illegal    = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_ctl    = ALU_ADD;
        next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_ctl    = r_alu(funct);
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        alu_ctl    = r_alu(funct);
        instr_done = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        if (state == S_I_EXEC) begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'd2;
          next_state = S_I_WB;
        end else begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        case (opcode)
          OP_ANDI: begin alu_ctl = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_ctl = ALU_OR;  ext_zero = 1'b1; end
          default: alu_ctl = ALU_ADD;
        endcase
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUB;
        pc_src     = 2'd1;
        pc_we      = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'd2;
        pc_we      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
      end
      S_JR: begin
        alu_src_a  = 1'b1;
        pc_src     = 2'd3;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset silences the datapath immediately, abandoning any in-flight instruction.
    if (rst) begin
      pc_we      = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      ext_zero   = 1'b0;
      alu_ctl    = 3'b000;
      pc_src     = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle expected control vectors are queued per
// instruction and popped/compared each cycle; a narrow-counter instance checks wrap.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;

  logic pc_we, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, ext_zero;
  logic instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_ctl;
  logic [3:0] state;
  logic [31:0] retired;

  logic s_pc_we, s_i_or_d, s_mem_read, s_mem_write, s_ir_write, s_reg_write, s_alu_src_a;
  logic s_ext_zero, s_instr_done, s_illegal;
  logic [1:0] s_reg_dst, s_mem_to_reg, s_alu_src_b, s_pc_src;
  logic [2:0] s_alu_ctl;
  logic [3:0] s_state;
  logic [2:0] s_retired;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctl(alu_ctl),
    .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal), .state(state),
    .retired(retired)
  );

  mc_control_fsm #(.CNT_W(3)) u_small (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(s_pc_we), .i_or_d(s_i_or_d), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .ir_write(s_ir_write), .reg_write(s_reg_write), .reg_dst(s_reg_dst),
    .mem_to_reg(s_mem_to_reg), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .ext_zero(s_ext_zero), .alu_ctl(s_alu_ctl), .pc_src(s_pc_src),
    .instr_done(s_instr_done), .illegal(s_illegal), .state(s_state), .retired(s_retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND = 3'b000, OR = 3'b001, SLT = 3'b111;

  logic [24:0] obs_v, s_obs_v;
  assign obs_v = {state, pc_we, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, ext_zero, alu_ctl, pc_src, instr_done,
                  illegal};
  assign s_obs_v = {s_state, s_pc_we, s_i_or_d, s_mem_read, s_mem_write, s_ir_write,
                    s_reg_write, s_reg_dst, s_mem_to_reg, s_alu_src_a, s_alu_src_b,
                    s_ext_zero, s_alu_ctl, s_pc_src, s_instr_done, s_illegal};

  logic [24:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_retired = 0;

  function automatic logic [24:0] mk(input logic [3:0] st, input logic we, input logic iod,
      input logic mr, input logic mw, input logic irw, input logic rw, input logic [1:0] rd,
      input logic [1:0] m2r, input logic a, input logic [1:0] b, input logic ez,
      input logic [2:0] alu, input logic [1:0] pcs, input logic done, input logic ill);
    mk = {st, we, iod, mr, mw, irw, rw, rd, m2r, a, b, ez, alu, pcs, done, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: compare at the falling edge, then advance past the rising edge.
  task automatic step(input string tag);
    logic [24:0] v;
    v = exp_q.pop_front();
    @(negedge clk);
    check({tag, "_ctl"}, {7'd0, obs_v}, {7'd0, v});
    check({tag, "_ctl_small"}, {7'd0, s_obs_v}, {7'd0, v});
    check({tag, "_retired"}, retired, exp_retired);
    check({tag, "_retired_small"}, {29'd0, s_retired}, {29'd0, exp_retired[2:0]});
    @(posedge clk);
    #1;
    if (v[1]) exp_retired = exp_retired + 1;
  endtask

  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [2:0] alu;
    logic ez;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, ADD, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, ADD, 0, 0, 0));
    case (op)
      6'h23: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ADD, 0, 0, 0));
        exp_q.push_back(mk(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 0, 1, 0));
      end
      6'h2B: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ADD, 0, 0, 0));
        exp_q.push_back(mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0));
      end
      6'h00: begin
        if (fn == 6'h08) begin
          exp_q.push_back(mk(13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 3, 1, 0));
        end else begin
          alu = (fn == 6'h20) ? ADD : (fn == 6'h22) ? SUB : (fn == 6'h24) ? AND :
                (fn == 6'h25) ? OR : SLT;
          exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, alu, 0, 0, 0));
          exp_q.push_back(mk(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, alu, 0, 1, 0));
        end
      end
      6'h04, 6'h05: begin
        exp_q.push_back(mk(8, (op == 6'h04) ? z : ~z, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, SUB, 1,
                           1, 0));
      end
      6'h02: exp_q.push_back(mk(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2, 1, 0));
      6'h03: exp_q.push_back(mk(12, 1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 3'b000, 2, 1, 0));
      default: begin
        alu = (op == 6'h08) ? ADD : (op == 6'h0C) ? AND : OR;
        ez  = (op != 6'h08);
        exp_q.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, ez, alu, 0, 0, 0));
        exp_q.push_back(mk(11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ez, alu, 0, 1, 0));
      end
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
    push_instr(op, fn, z);
    while (exp_q.size() > 0) step(tag);
  endtask

  task automatic run_illegal(input string tag, input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    zero   = 1'b0;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, ADD, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, ADD, 0, 0, 1));
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, ADD, 0, 0, 0));
    while (exp_q.size() > 0) step(tag);
    // The trailing FETCH above has been entered; finish that instruction with a j.
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, ADD, 0, 0, 0));
    exp_q.push_back(mk(9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2, 1, 0));
    opcode = 6'h02;
    while (exp_q.size() > 0) step({tag, "_j"});
  endtask

  initial begin
    // Reset from power-up
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_enables", {25'd0, pc_we, mem_read, mem_write, ir_write, reg_write,
                            instr_done, illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr("lw", 6'h23, 6'h00, 1'b0);
    run_instr("sw", 6'h2B, 6'h00, 1'b0);
    run_instr("r_add", 6'h00, 6'h20, 1'b0);
    run_instr("r_slt", 6'h00, 6'h2A, 1'b0);
    run_instr("r_sub", 6'h00, 6'h22, 1'b1);
    run_instr("r_and", 6'h00, 6'h24, 1'b0);
    run_instr("r_or", 6'h00, 6'h25, 1'b0);
    run_instr("addi", 6'h08, 6'h3F, 1'b0);
    run_instr("andi", 6'h0C, 6'h00, 1'b0);
    run_instr("ori", 6'h0D, 6'h00, 1'b0);
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1);
    run_instr("beq_not", 6'h04, 6'h00, 1'b0);
    run_instr("bne_taken", 6'h05, 6'h00, 1'b0);
    run_instr("bne_not", 6'h05, 6'h00, 1'b1);
    run_instr("j", 6'h02, 6'h00, 1'b0);
    run_instr("jal", 6'h03, 6'h00, 1'b0);
    run_instr("jr", 6'h00, 6'h08, 1'b0);
    run_illegal("illegal_op", 6'h3F, 6'h00);
    run_illegal("illegal_fn", 6'h00, 6'h3F);
    for (int i = 0; i < 3; i++) begin
      run_instr("rand_sw", 6'h2B, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    // Reset while a lw sits in MEM_RD: no write may follow.
    opcode = 6'h23;
    exp_q.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, ADD, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, ADD, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, ADD, 0, 0, 0));
    while (exp_q.size() > 0) step("rst_lw");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", {28'd0, state}, 32'd3);
    check("rst_mid_enables", {25'd0, pc_we, mem_read, mem_write, ir_write, reg_write,
                              instr_done, illegal}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state2", {28'd0, state}, 32'd0);
    check("rst_mid_enables2", {25'd0, pc_we, mem_read, mem_write, ir_write, reg_write,
                               instr_done, illegal}, 32'd0);
    check("rst_mid_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_retired = 0;
    run_instr("post_rst_j", 6'h02, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) run_instr("wrap_sw", 6'h2B, 6'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
